elevator_scan: RTL

ELEVATOR_SCAN -- requirements
Module: elevator_scan

---
 rtl/elevator_scan.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/elevator_scan.sv
// elevator_scan: single-car SCAN elevator controller.
//   The car keeps travelling in its current direction while any request lies
//   ahead of it, stops at every requested floor on the way, and only reverses
//   once nothing remains ahead.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_valid  a floor request is presented this cycle
//   req_floor  requested floor (ignored when >= FLOORS)
//   cur_floor  floor the car is at (or has most recently left)
//   up / dwn   car moving up / down
//   door       door open
//   stop       car stationary (idle or door open)
//   pending    outstanding-request bitmap, bit i = floor i
//   busy       car not idle, or requests outstanding
module elevator_scan #(
  parameter int FLOORS      = 16,
  parameter int FW          = $clog2(FLOORS),
  parameter int MOVE_CYCLES = 2,
  parameter int DOOR_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [FW-1:0]     req_floor,
  output logic [FW-1:0]     cur_floor,
  output logic              up,
  output logic              dwn,
  output logic              door,
  output logic              stop,
  output logic [FLOORS-1:0] pending,
  output logic              busy
);

  localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_CYCLES - 1);
  localparam logic [FW-1:0] TOP       = FW'(FLOORS - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR_OPEN} state_t;

  state_t            state, state_n;
  logic [FW-1:0]     floor_n;
  logic              dir, dir_n;          // 1 = up
  logic [FLOORS-1:0] pend_n;
  logic [MW-1:0]     mcnt, mcnt_n;
  logic [DW-1:0]     dcnt, dcnt_n;

  logic              req_ok, req_here, any_above, any_below, arrive_hit, at_edge;
  logic [FW-1:0]     next_floor;
  logic [FLOORS-1:0] req_oh, cur_oh, nxt_oh, above_m, below_m;

  // Request decode and floor masks relative to the car position.
  always_comb begin
    req_ok     = req_valid && (32'(req_floor) < 32'(FLOORS));
    req_here   = req_ok && (req_floor == cur_floor);
    next_floor = (state == MOVE_UP) ? cur_floor + 1'b1 : cur_floor - 1'b1;
    for (int i = 0; i < FLOORS; i++) begin
      req_oh[i]  = req_ok && (req_floor == FW'(i));
      cur_oh[i]  = (cur_floor == FW'(i));
      nxt_oh[i]  = (next_floor == FW'(i));
      above_m[i] = pending[i] && (FW'(i) > cur_floor);
      below_m[i] = pending[i] && (FW'(i) < cur_floor);
    end
    any_above  = |above_m;
    any_below  = |below_m;
    // A same-cycle request for the arrival floor stops the car too.
    arrive_hit = |(nxt_oh & (pending | req_oh));
    // Defensive: never step past either end of the shaft.
    at_edge    = ((state == MOVE_UP) && (cur_floor == TOP)) ||
                 ((state == MOVE_DN) && (cur_floor == '0));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur_floor <= '0;
      dir       <= 1'b1;
      pending   <= '0;
      mcnt      <= '0;
      dcnt      <= '0;
    end else begin
      state     <= state_n;
      cur_floor <= floor_n;
      dir       <= dir_n;
      pending   <= pend_n;
      mcnt      <= mcnt_n;
      dcnt      <= dcnt_n;
    end
  end

  // Next-state logic. By default a valid request just sets its pending bit.
  always_comb begin
    state_n = state;
    floor_n = cur_floor;
    dir_n   = dir;
    pend_n  = pending | req_oh;
    mcnt_n  = mcnt;
    dcnt_n  = dcnt;
    unique case (state)
      IDLE: begin
        if (req_here) begin
          // Already there: just open the door, nothing to remember.
          pend_n  = pending;
          state_n = DOOR_OPEN;
          dcnt_n  = DOOR_LOAD;
        end else if (any_above && (dir || !any_below)) begin
          state_n = MOVE_UP;
          dir_n   = 1'b1;
          mcnt_n  = '0;
        end else if (any_below) begin
          state_n = MOVE_DN;
          dir_n   = 1'b0;
          mcnt_n  = '0;
        end else if (|(pending & cur_oh)) begin
          state_n = DOOR_OPEN;
          dcnt_n  = DOOR_LOAD;
          pend_n  = (pending | req_oh) & ~cur_oh;
        end
      end
      MOVE_UP, MOVE_DN: begin
        if (at_edge) begin
          state_n = IDLE;
          mcnt_n  = '0;
        end else if (mcnt == MOVE_LAST) begin
          mcnt_n  = '0;
          floor_n = next_floor;
          if (arrive_hit) begin
            state_n = DOOR_OPEN;
            dcnt_n  = DOOR_LOAD;
            pend_n  = (pending | req_oh) & ~nxt_oh;
          end
        end else begin
          mcnt_n = mcnt + 1'b1;
        end
      end
      DOOR_OPEN: begin
        if (req_here) begin
          // Someone pressed the button for this floor: hold the door longer.
          pend_n = pending;
          dcnt_n = DOOR_LOAD;
        end else if (dcnt == '0) begin
          mcnt_n = '0;
          if (dir ? any_above : any_below) begin
            state_n = dir ? MOVE_UP : MOVE_DN;
          end else if (dir ? any_below : any_above) begin
            state_n = dir ? MOVE_DN : MOVE_UP;
            dir_n   = !dir;
          end else begin
            state_n = IDLE;
          end
        end else begin
          dcnt_n = dcnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    up   = (state == MOVE_UP);
    dwn  = (state == MOVE_DN);
    door = (state == DOOR_OPEN);
    stop = (state == IDLE) || (state == DOOR_OPEN);
    busy = (state != IDLE) || (|pending);
  end

endmodule
